// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store access unit between a core and a word-addressed data memory
//
// Purpose: accepts one load/store request at a time, performs a single-cycle
// memory access, and holds an extended/zeroed response until the core takes it.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   req_valid/req_ready                 request handshake
//   req_store, req_size, req_unsigned   request kind, size (00 b, 01 h, 10 w, 11 illegal), extension
//   req_addr, req_wdata                 word address and store data
//   rsp_valid/rsp_ready                 response handshake
//   rsp_rdata, rsp_err                  extended load data (0 for stores), illegal-size flag
//   mem_we, mem_a, mem_wd, mem_rd       data memory port (mem_rd is combinational)

module mem_access_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [1:0]            mem_we,
  output logic [DATA_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]            state_q,    state_d;
  logic                  store_q,    store_d;
  logic [1:0]            size_q,     size_d;
  logic                  unsigned_q, unsigned_d;
  logic [DATA_WIDTH-1:0] addr_q,     addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
  logic                  err_q,      err_d;

  logic                  accept;
  logic [DATA_WIDTH-1:0] load_ext;

  // A new request may be taken in the same cycle the current response retires.
  assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_a     = addr_q;
  assign mem_wd    = wdata_q;

  // Decoded straight from state so an asynchronous reset during ACCESS kills
  // the write enable without waiting for a clock edge.
  always_comb begin
    mem_we = 2'b00;
    if ((state_q == ST_ACCESS) && store_q) begin
      case (size_q)
        SZ_BYTE: mem_we = 2'b11;
        SZ_HALF: mem_we = 2'b10;
        SZ_WORD: mem_we = 2'b01;
        default: mem_we = 2'b00;
      endcase
    end
  end

  always_comb begin
    load_ext = mem_rd;
    case (size_q)
      SZ_BYTE: load_ext = {{(DATA_WIDTH-8){~unsigned_q & mem_rd[7]}}, mem_rd[7:0]};
      SZ_HALF: load_ext = {{(DATA_WIDTH-16){~unsigned_q & mem_rd[15]}}, mem_rd[15:0]};
      default: load_ext = mem_rd;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    store_d    = store_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;

    if (accept) begin
      store_d    = req_store;
      size_d     = req_size;
      unsigned_d = req_unsigned;
      addr_d     = req_addr;
      wdata_d    = req_wdata;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (size_q == 2'b11) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (store_q) begin
          rdata_d = '0;
          err_d   = 1'b0;
        end else begin
          rdata_d = load_ext;
          err_d   = 1'b0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = accept ? ST_ACCESS : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      store_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      store_q    <= store_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_we(mem_we), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Behavioural data memory with a backdoor write port for preloading.
  logic [31:0] mem [0:15];
  logic        bd_we = 1'b0;
  logic [3:0]  bd_addr = 4'd0;
  logic [31:0] bd_data = 32'd0;

  assign mem_rd = mem[mem_a[3:0]];

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else begin
      case (mem_we)
        2'b01: mem[mem_a[3:0]] <= mem_wd;
        2'b10: mem[mem_a[3:0]][15:0] <= mem_wd[15:0];
        2'b11: mem[mem_a[3:0]][7:0] <= mem_wd[7:0];
        default: ;
      endcase
    end
  end

  int          we_total = 0;
  logic [1:0]  we_last = 2'b00;
  always @(negedge clk) begin
    if (mem_we != 2'b00) begin
      we_total <= we_total + 1;
      we_last  <= mem_we;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic run_req(input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = wd; rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_er;
    logic [1:0]  exp_we;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] rd, hold_rd;
    logic        er, hold_er;
    int          lat, we0, n;

    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;

    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'd5, 32'hDEADBEEF, 32'h0,        1'b0, 2'b01};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'd5, 32'h0,        32'hDEADBEEF, 1'b0, 2'b00};
    vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'd3, 32'hFFFFFFAB, 32'h0,        1'b0, 2'b11};
    vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'd3, 32'h0,        32'h123456AB, 1'b0, 2'b00};
    vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'd3, 32'h0,        32'hFFFFFFAB, 1'b0, 2'b00};
    vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'd3, 32'h0,        32'h000000AB, 1'b0, 2'b00};
    vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'd7, 32'h0,        32'hFFFF8001, 1'b0, 2'b00};
    vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'd7, 32'h0,        32'h00008001, 1'b0, 2'b00};
    vecs[8]  = '{1'b1, 2'b11, 1'b0, 32'd2, 32'h0BADF00D, 32'h0,        1'b1, 2'b00};
    vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'd2, 32'h0,        32'h55AA55AA, 1'b0, 2'b00};
    vecs[10] = '{1'b0, 2'b11, 1'b1, 32'd7, 32'h0,        32'h0,        1'b1, 2'b00};
    vecs[11] = '{1'b1, 2'b01, 1'b0, 32'd7, 32'h1234ABCD, 32'h0,        1'b0, 2'b10};
    vecs[12] = '{1'b0, 2'b01, 1'b0, 32'd7, 32'h0,        32'hFFFFABCD, 1'b0, 2'b00};

    // Reset state
    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_rsp_rdata", rsp_rdata,      32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_a",     mem_a,          32'd0);
    chk("rst_mem_wd",    mem_wd,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    preload(4'd3, 32'h12345678);
    preload(4'd7, 32'h00008001);
    preload(4'd2, 32'h55AA55AA);
    preload(4'd9, 32'h00000000);

    for (int i = 0; i < 13; i++) begin
      we0 = we_total;
      run_req(vecs[i].st, vecs[i].sz, vecs[i].un, vecs[i].a, vecs[i].wd, rd, er, lat);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_er));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("v%0d_we_cycles", i), 32'(we_total - we0),
          (vecs[i].exp_we != 2'b00) ? 32'd1 : 32'd0);
      if (vecs[i].exp_we != 2'b00) chk($sformatf("v%0d_we_code", i), 32'(we_last), 32'(vecs[i].exp_we));
    end
    chk("mem2_untouched", mem[2], 32'h55AA55AA);
    chk("mem3_byte_store", mem[3], 32'h123456AB);

    // Back-pressure for 5 cycles, then back-to-back accept in RESP
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'd5; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    hold_rd = rsp_rdata; hold_er = rsp_err;
    chk("bp_first_rdata", hold_rd, 32'hDEADBEEF);
    we0 = we_total;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("bp%0d_valid", c), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d_rdata", c), rsp_rdata, hold_rd);
      chk($sformatf("bp%0d_err", c), 32'(rsp_err), 32'(hold_er));
      chk($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'd0);
      chk($sformatf("bp%0d_mem_we", c), 32'(mem_we), 32'd0);
    end
    chk("bp_no_writes", 32'(we_total - we0), 32'd0);
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'b00; req_unsigned = 1'b1;
    req_addr = 32'd3; rsp_ready = 1'b1;
    #1;
    chk("b2b_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_access_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("b2b_resp_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_resp_rdata", rsp_rdata, 32'h000000AB);
    @(posedge clk); #1;

    // Reset during ACCESS of a word store
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'b10; req_addr = 32'd9;
    req_wdata = 32'h11111111; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_we_before", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_we_reset", 32'(mem_we), 32'd0);
    chk("mid_valid_reset", 32'(rsp_valid), 32'd0);
    chk("mid_mem_a_reset", mem_a, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_req_ready", 32'(req_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("mid_no_rsp%0d", c), 32'(rsp_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
